// File: rtl/ins_fetch_arbiter_if.sv
// Bus bundle for ins_fetch_arbiter: fetch request/response, loader byte-write
// port and the shared byte-wide instruction memory port.
interface ins_fetch_arbiter_if #(
    parameter int ADDR_W = 7
);
    // Handshakes: fetch_req and load_req are levels sampled only while the
    // arbiter is idle; fetch_ready and load_ack are single-cycle registered
    // completion pulses, and fetch_ins/fetch_err are meaningful with fetch_ready.
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_ready;
    logic [31:0]       fetch_ins;
    logic              fetch_err;
    logic              load_req;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_data;
    logic              load_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              busy;

    modport slave (
        input  fetch_req, fetch_addr, load_req, load_addr, load_data, mem_rdata,
        output fetch_ready, fetch_ins, fetch_err, load_ack,
               mem_addr, mem_we, mem_wdata, busy
    );

    modport master (
        output fetch_req, fetch_addr, load_req, load_addr, load_data, mem_rdata,
        input  fetch_ready, fetch_ins, fetch_err, load_ack,
               mem_addr, mem_we, mem_wdata, busy
    );
endinterface

// File: rtl/ins_fetch_arbiter.sv
// Instruction fetch sequencer: four big-endian byte reads per 32-bit word,
// sharing the memory port with a fixed-priority program-loader write port.
module ins_fetch_arbiter #(
    parameter int ADDR_W    = 7,
    parameter int MEM_DEPTH = 128
) (
    input  logic                 CLK,
    input  logic                 Reset,
    ins_fetch_arbiter_if.slave   bus,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DONE  = 3'd2,
        S_ERR   = 3'd3,
        S_LOAD  = 3'd4
    } state_t;

    localparam logic [31:0]     LAST_BASE = 32'(MEM_DEPTH - 4);
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(MEM_DEPTH);

    state_t            state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0] base;
    logic [31:0]       shadow;
    logic              fetch_bad;
    logic              load_ok;

    logic              fetch_ready_q;
    logic              fetch_err_q;
    logic [31:0]       fetch_ins_q;
    logic              load_ack_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [7:0]        mem_wdata_q;

    assign fetch_bad = (bus.fetch_addr[1:0] != 2'b00) || (bus.fetch_addr > LAST_BASE);
    assign load_ok   = {1'b0, bus.load_addr} < DEPTH_L;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (bus.load_req) begin
                    state_nxt = S_LOAD;
                end else if (bus.fetch_req) begin
                    state_nxt = fetch_bad ? S_ERR : S_FETCH;
                    cnt_nxt   = 3'd0;
                end
            end
            S_FETCH: begin
                if (cnt == 3'd4) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            S_LOAD:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // All bus outputs are registered: each is loaded with the value that the
    // state being entered must present, so strobes line up with that state.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            base          <= '0;
            shadow        <= 32'd0;
            fetch_ready_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            fetch_ins_q   <= 32'd0;
            load_ack_q    <= 1'b0;
            mem_addr_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= 8'd0;
        end else begin
            fetch_ready_q <= (state_nxt == S_DONE) || (state_nxt == S_ERR);
            fetch_err_q   <= (state_nxt == S_ERR);
            load_ack_q    <= (state_nxt == S_LOAD);
            mem_we_q      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (state_nxt == S_LOAD) begin
                        mem_addr_q  <= bus.load_addr;
                        mem_wdata_q <= bus.load_data;
                        mem_we_q    <= load_ok;
                    end else if (state_nxt == S_FETCH) begin
                        base       <= bus.fetch_addr[ADDR_W-1:0];
                        mem_addr_q <= bus.fetch_addr[ADDR_W-1:0];
                        shadow     <= 32'd0;
                    end else if (state_nxt == S_ERR) begin
                        fetch_ins_q <= 32'd0;
                    end
                end
                S_FETCH: begin
                    if (cnt < 3'd3) begin
                        mem_addr_q <= base + ADDR_W'(cnt + 3'd1);
                    end
                    // Read data lags the address by one cycle, so cnt k holds byte k-1.
                    case (cnt)
                        3'd1: shadow[31:24] <= bus.mem_rdata;
                        3'd2: shadow[23:16] <= bus.mem_rdata;
                        3'd3: shadow[15:8]  <= bus.mem_rdata;
                        3'd4: begin
                            shadow[7:0] <= bus.mem_rdata;
                            fetch_ins_q <= {shadow[31:8], bus.mem_rdata};
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.fetch_ready = fetch_ready_q;
    assign bus.fetch_err   = fetch_err_q;
    assign bus.fetch_ins   = fetch_ins_q;
    assign bus.load_ack    = load_ack_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.busy        = (state != S_IDLE);
    assign dbg_state       = state;

endmodule

// File: tb/tb_ins_fetch_arbiter.sv
// Self-checking bench for ins_fetch_arbiter: directed fetch/load vectors with a
// byte memory model, expected-response queues and a negedge monitor.
module tb_ins_fetch_arbiter;

    localparam int ADDR_W    = 7;
    localparam int MEM_DEPTH = 128;

    logic       CLK;
    logic       Reset;
    logic [2:0] dbg_state;
    int         cyc;
    int         n_cmp;
    int         n_err;

    logic [32:0] exp_q[$];
    logic [15:0] ld_q[$];
    logic [32:0] mon_f;
    logic [15:0] mon_l;
    logic [7:0]  mem [MEM_DEPTH];

    ins_fetch_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    ins_fetch_arbiter #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock, cycle counter and synchronous-read byte memory
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge CLK) begin
        if (Reset) begin
            if (bus.fetch_ready) begin
                check("fetch_ready_exclusive", {62'd0, bus.load_ack, bus.mem_we}, 64'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_fetch_ready: got ins=%08h err=%0b, required no response",
                             bus.fetch_ins, bus.fetch_err);
                end else begin
                    mon_f = exp_q.pop_front();
                    check("fetch_ins", 64'(bus.fetch_ins), 64'(mon_f[31:0]));
                    check("fetch_err", 64'(bus.fetch_err), 64'(mon_f[32]));
                end
            end
            if (bus.load_ack) begin
                if (ld_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_load_ack: got addr=%0h, required no ack", bus.mem_addr);
                end else begin
                    mon_l = ld_q.pop_front();
                    check("load_write", 64'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'(mon_l));
                end
            end
        end
    end

    // Driver tasks
    task automatic wait_idle();
        int n = 0;
        while (dbg_state != 3'd0 && n < 30) begin
            @(posedge CLK); #1;
            n++;
        end
        check("wait_idle_timeout", 64'(n < 30), 64'd1);
    endtask

    task automatic do_load(input logic [6:0] addr, input logic [7:0] data);
        int n;
        wait_idle();
        ld_q.push_back({1'b1, addr, data});
        @(negedge CLK);
        bus.load_req  = 1'b1;
        bus.load_addr = addr;
        bus.load_data = data;
        n = 0;
        do begin
            @(posedge CLK); #1;
            n++;
        end while (!bus.load_ack && n < 10);
        bus.load_req = 1'b0;
        check("load_latency", 64'(n), 64'd1);
        @(posedge CLK); #1;
        check("mem_we_one_cycle", 64'(bus.mem_we), 64'd0);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] ins,
                            input logic err, input int lat);
        int n;
        logic [6:0] ma0;
        wait_idle();
        exp_q.push_back({err, ins});
        @(negedge CLK);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = addr;
        ma0 = bus.mem_addr;
        @(posedge CLK); #1;
        bus.fetch_req = 1'b0;
        n = 1;
        while (!bus.fetch_ready && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        check("fetch_latency", 64'(n), 64'(lat));
        if (err) check("err_no_mem_access", 64'(bus.mem_addr), 64'(ma0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fetch_ins"},   64'(bus.fetch_ins),   64'd0);
        check({tag, "_fetch_ready"}, 64'(bus.fetch_ready), 64'd0);
        check({tag, "_fetch_err"},   64'(bus.fetch_err),   64'd0);
        check({tag, "_load_ack"},    64'(bus.load_ack),    64'd0);
        check({tag, "_mem_we"},      64'(bus.mem_we),      64'd0);
        check({tag, "_mem_addr"},    64'(bus.mem_addr),    64'd0);
        check({tag, "_mem_wdata"},   64'(bus.mem_wdata),   64'd0);
        check({tag, "_busy"},        64'(bus.busy),        64'd0);
        check({tag, "_state"},       64'(dbg_state),       64'd0);
    endtask

    task automatic report();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        n_err++;
        report();
        $fatal(1);
    end

    // Directed test sequence
    initial begin
        logic [6:0] pl_addr [12];
        logic [7:0] pl_data [12];
        int t1, t2, n;

        pl_addr = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7,
                    7'd124, 7'd125, 7'd126, 7'd127};
        pl_data = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44,
                    8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 8'h00;
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = 32'd0;
        bus.load_req   = 1'b0;
        bus.load_addr  = '0;
        bus.load_data  = 8'd0;
        Reset = 1'b1;
        #2 Reset = 1'b0;
        repeat (3) @(posedge CLK);
        #1 check_all_zero("reset");
        @(negedge CLK) Reset = 1'b1;

        for (int i = 0; i < 12; i++) do_load(pl_addr[i], pl_data[i]);

        // Basic fetch and boundary addresses
        do_fetch(32'h0000_0000, 32'h2008_0005, 1'b0, 6);
        do_fetch(32'h0000_007C, 32'hDEAD_BEEF, 1'b0, 6);
        do_fetch(32'h0000_0080, 32'h0000_0000, 1'b1, 1);
        do_fetch(32'h0000_0002, 32'h0000_0000, 1'b1, 1);
        do_fetch(32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1);
        do_fetch(32'h0000_0004, 32'h1122_3344, 1'b0, 6);

        // Simultaneous load and fetch: the load wins, the fetch follows
        wait_idle();
        ld_q.push_back({1'b1, 7'd1, 8'hAB});
        exp_q.push_back({1'b0, 32'h20AB_0005});
        @(negedge CLK);
        bus.load_req   = 1'b1;
        bus.load_addr  = 7'd1;
        bus.load_data  = 8'hAB;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'd0;
        @(posedge CLK); #1;
        bus.load_req = 1'b0;
        check("sim_load_first", 64'(bus.load_ack), 64'd1);
        @(posedge CLK); #1;
        check("sim_we_one_cycle", 64'(bus.mem_we), 64'd0);
        n = 0;
        while (!bus.fetch_ready && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        bus.fetch_req = 1'b0;
        check("sim_fetch_latency", 64'(n), 64'd6);

        // Held fetch_req gives back-to-back fetches every 7 cycles
        wait_idle();
        exp_q.push_back({1'b0, 32'h20AB_0005});
        exp_q.push_back({1'b0, 32'h20AB_0005});
        @(negedge CLK);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'd0;
        n = 0;
        do begin @(posedge CLK); #1; n++; end while (!bus.fetch_ready && n < 20);
        t1 = cyc;
        n = 0;
        do begin @(posedge CLK); #1; n++; end while (!bus.fetch_ready && n < 20);
        t2 = cyc;
        bus.fetch_req = 1'b0;
        check("fetch_throughput", 64'(t2 - t1), 64'd7);

        // Load raised at FETCH cnt=2 waits until after DONE
        wait_idle();
        exp_q.push_back({1'b0, 32'h1122_3344});
        @(negedge CLK);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'd4;
        @(posedge CLK); #1;
        bus.fetch_req = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        check("busy_in_fetch", 64'(bus.busy), 64'd1);
        ld_q.push_back({1'b1, 7'd5, 8'h99});
        bus.load_req  = 1'b1;
        bus.load_addr = 7'd5;
        bus.load_data = 8'h99;
        n = 0;
        while (!bus.fetch_ready && n < 20) begin @(posedge CLK); #1; n++; end
        t1 = cyc;
        n = 0;
        while (!bus.load_ack && n < 20) begin @(posedge CLK); #1; n++; end
        t2 = cyc;
        bus.load_req = 1'b0;
        check("pending_load_after_done", 64'(t2 - t1), 64'd2);
        do_fetch(32'h0000_0004, 32'h1199_3344, 1'b0, 6);

        // Reset at FETCH cnt=3 aborts the fetch with no response
        wait_idle();
        @(negedge CLK);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'd0;
        @(posedge CLK); #1;
        bus.fetch_req = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        Reset = 1'b0;
        #1 check_all_zero("midfetch_reset");
        repeat (2) @(negedge CLK);
        Reset = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        do_fetch(32'h0000_0000, 32'h20AB_0005, 1'b0, 6);

        repeat (3) @(posedge CLK);
        check("fetch_queue_drained", 64'(exp_q.size()), 64'd0);
        check("load_queue_drained",  64'(ld_q.size()),  64'd0);
        report();
        $finish;
    end

endmodule

// File: doc/ins_fetch_arbiter.md
# ins_fetch_arbiter

Sequencer and arbiter for the byte-wide instruction memory of the multi-cycle CPU. It turns a single fetch request from the control unit into four sequential byte reads and assembles them big-endian into a 32-bit instruction. It also shares the same memory port with a program-loader byte-write port, so instructions can be written at run time instead of only from a file at elaboration.

## Interface

Parameters:
- ADDR_W, 7, byte-address width of the memory port.
- MEM_DEPTH, 128, number of bytes in the memory; must be ≤ 2^ADDR_W.

Ports:
- CLK  in  1  single clock, rising-edge.
- Reset  in  1  asynchronous, active-low reset.
- fetch_req  in  1  control unit requests an instruction; level, sampled only in IDLE.
- fetch_addr  in  32  byte address of the instruction (PC).
- fetch_ready  out  1  one-cycle pulse: fetch_ins / fetch_err valid.
- fetch_ins  out  32  assembled instruction; held until the next completion.
- fetch_err  out  1  valid with fetch_ready: address misaligned or out of range.
- load_req  in  1  loader requests a byte write; level, sampled only in IDLE.
- load_addr  in  ADDR_W  byte address to write.
- load_data  in  8  byte to write.
- load_ack  out  1  one-cycle pulse: write performed this cycle.
- mem_addr  out  ADDR_W  memory byte address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data; synchronous, valid the cycle after mem_addr is presented.
- busy  out  1  high in any state other than IDLE.

## Operation

- FSM states: IDLE, FETCH, DONE, ERR, LOAD.
- IDLE behaviour:
  - If load_req=1, go to LOAD; the loader has fixed priority.
  - Otherwise, if fetch_req=1, latch fetch_addr as base. If base[1:0]≠0 or base > MEM_DEPTH−4, go to ERR; otherwise go to FETCH with cnt=0.
  - Otherwise stay in IDLE.
- FETCH uses a 3-bit counter cnt, 0..4:
  - For cnt 0..3, drive mem_addr = base[ADDR_W−1:0] + cnt with mem_we=0.
  - For cnt 1..4, capture mem_rdata into the byte that was addressed the previous cycle.
  - After the cnt=4 cycle, go to DONE.
- Byte order is big-endian: byte at base+0 → fetch_ins[31:24], +1 → [23:16], +2 → [15:8], +3 → [7:0].
- Bytes are assembled in an internal shadow register. fetch_ins updates only on entry to DONE, so it never shows a partial word.
- DONE: fetch_ready=1, fetch_err=0, then go to IDLE.
- ERR: no memory access. Set fetch_ins=0, fetch_ready=1, fetch_err=1, then go to IDLE.
- LOAD: a single cycle. mem_addr, mem_wdata and mem_we=1 are driven from values latched at acceptance, with load_ack=1, then go to IDLE.
  - load_addr ≥ MEM_DEPTH: the write is suppressed (mem_we=0) but load_ack is still pulsed.
- A fetch in progress is never preempted. A load_req raised during FETCH waits for the next IDLE.
- A held fetch_req after fetch_ready starts a new fetch from the following IDLE cycle.
- In IDLE, mem_we=0 and mem_addr holds its last value.

## Timing

- Reset (Reset=0, asynchronous):
  - State goes to IDLE, cnt=0.
  - fetch_ins=0, fetch_ready=0, fetch_err=0, load_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
- Reset asserted mid-FETCH or mid-LOAD aborts the operation immediately: no fetch_ready or load_ack is issued, and the shadow register is cleared.
- Fetch latency, with E0 the acceptance edge: FETCH occupies the cycles after E0..E4, and fetch_ready is high in the cycle after E5.
- Fetch throughput: one instruction per 7 cycles (IDLE + 5×FETCH + DONE).
- Error latency: fetch_ready/fetch_err are high in the cycle after the acceptance edge.
- Load latency: load_ack and mem_we are high in the cycle after the acceptance edge. Throughput is one byte per 2 cycles.
- Simultaneous load_req and fetch_req in IDLE: LOAD first, then the fetch is accepted in the next IDLE if fetch_req is still high.
- fetch_ready, load_ack and mem_we are never high in the same cycle.
- fetch_ready, fetch_err and load_ack are registered outputs.

## Test plan

- Reset, then preload bytes 0x20,0x08,0x00,0x05 at addresses 0..3. fetch_req with fetch_addr=0 → fetch_ready pulses in cycle 6 after acceptance, with fetch_ins=0x20080005 and fetch_err=0.
- fetch_addr=0x7C with MEM_DEPTH=128 → valid fetch of bytes 124..127. fetch_addr=0x80 → ERR: fetch_err=1, fetch_ins=0, and mem_addr never driven above 127.
- fetch_addr=0x02 → ERR pulse one cycle after acceptance, and no memory read issued.
- load_req and fetch_req asserted together in IDLE → load_ack first, with mem_we=1 for exactly one cycle. The fetch then completes and returns the newly written byte at its position.
- load_req raised at FETCH cnt=2 → the write waits until after DONE, and the fetched word is unaffected by the pending write.
- Reset pulsed at FETCH cnt=3 → all outputs are 0 immediately and no fetch_ready follows. A subsequent fetch returns the correct word.
